// File: rtl/arm_mc_pkg.sv
// Shared types and constants for the multicycle ARM control unit.
package arm_mc_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    EXECR,
    EXECI,
    ALUWB,
    BRANCH,
    MULEX
  } state_t;

  // ALUControl encodings
  localparam int unsigned ALU_ADD = 0;
  localparam int unsigned ALU_SUB = 1;
  localparam int unsigned ALU_AND = 2;
  localparam int unsigned ALU_ORR = 3;
  localparam int unsigned ALU_EOR = 4;
  localparam int unsigned ALU_MOV = 5;
  localparam int unsigned ALU_MUL = 6;

  // Instr[27:26]
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // Data-processing cmd field, Funct[4:1]
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  // Condition codes, Instr[31:28]
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

endpackage

// File: rtl/arm_mc_controller_if.sv
// Control-unit <-> datapath bundle. master = control unit, slave = datapath.
interface arm_mc_controller_if #(
  parameter int unsigned ALUCTRL_W = 4
);
  logic [31:0]          Instr;
  logic [3:0]           ALUFlags;
  logic                 PCWrite;
  logic                 AdrSrc;
  logic                 MemWrite;
  logic                 IRWrite;
  logic [1:0]           ResultSrc;
  logic [ALUCTRL_W-1:0] ALUControl;
  logic [1:0]           ALUSrcA;
  logic [1:0]           ALUSrcB;
  logic [1:0]           ImmSrc;
  logic                 RegWrite;
  logic [1:0]           RegSrc;

  modport master (
    input  Instr, ALUFlags,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
           ALUSrcA, ALUSrcB, ImmSrc, RegWrite, RegSrc
  );

  modport slave (
    output Instr, ALUFlags,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
           ALUSrcA, ALUSrcB, ImmSrc, RegWrite, RegSrc
  );
endinterface

// File: rtl/arm_mc_condlogic.sv
// NZCV flags register with split NZ / CV write enables, plus condition evaluation.
module arm_mc_condlogic
  import arm_mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond_i,
  input  logic [3:0] alu_flags_i,
  input  logic       nz_we_i,
  input  logic       cv_we_i,
  output logic       cond_ex_o
);
  logic [3:0] flags_q;
  logic       n, z, c, v;

  assign {n, z, c, v} = flags_q;

  // Condition check against the registered flags
  always_comb begin
    cond_ex_o = 1'b0;
    case (cond_i)
      COND_EQ: cond_ex_o = z;
      COND_NE: cond_ex_o = ~z;
      COND_CS: cond_ex_o = c;
      COND_CC: cond_ex_o = ~c;
      COND_MI: cond_ex_o = n;
      COND_PL: cond_ex_o = ~n;
      COND_VS: cond_ex_o = v;
      COND_VC: cond_ex_o = ~v;
      COND_HI: cond_ex_o = c & ~z;
      COND_LS: cond_ex_o = ~c | z;
      COND_GE: cond_ex_o = (n == v);
      COND_LT: cond_ex_o = (n != v);
      COND_GT: cond_ex_o = ~z & (n == v);
      COND_LE: cond_ex_o = z | (n != v);
      COND_AL: cond_ex_o = 1'b1;
      default: cond_ex_o = 1'b0;
    endcase
  end

  // Flag register; a failed condition suppresses the update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= 4'b0000;
    end else begin
      if (nz_we_i && cond_ex_o) flags_q[3:2] <= alu_flags_i[3:2];
      if (cv_we_i && cond_ex_o) flags_q[1:0] <= alu_flags_i[1:0];
    end
  end

endmodule

// File: rtl/arm_mc_controller.sv
// Multicycle ARM control unit: main FSM, instruction decode and optional multicycle MUL.
module arm_mc_controller
  import arm_mc_pkg::*;
#(
  parameter int unsigned ALUCTRL_W  = 4,
  parameter bit          EN_MUL     = 1'b1,
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  arm_mc_controller_if.master bus
);
  localparam int unsigned CntW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MUL_CYCLES - 1);

  state_t          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] cmd;
  logic       s_bit;
  logic [3:0] rd;
  logic       is_mul, is_cmp;

  logic [ALUCTRL_W-1:0] dp_alu, alu_ctrl;
  logic dp_valid, dp_arith, dp_nz_we, dp_cv_we, no_write;
  logic next_pc, branch, reg_w, mem_w, ir_w, adr_src;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic nz_we, cv_we, cond_ex;

  logic unused_instr;
  assign unused_instr = ^{bus.Instr[19:16], bus.Instr[11:8], bus.Instr[3:0]};

  assign op     = bus.Instr[27:26];
  assign funct  = bus.Instr[25:20];
  assign cmd    = funct[4:1];
  assign s_bit  = funct[0];
  assign rd     = bus.Instr[15:12];
  assign is_mul = EN_MUL && (op == OP_DP) && (funct[5:1] == 5'b00000)
                  && (bus.Instr[7:4] == 4'b1001);
  assign is_cmp = (cmd == CMD_CMP);

  // Data-processing cmd decode; unknown cmds run as ADD but never write back
  always_comb begin
    dp_alu   = ALUCTRL_W'(ALU_ADD);
    dp_valid = 1'b1;
    dp_arith = 1'b0;
    case (cmd)
      CMD_ADD: dp_arith = 1'b1;
      CMD_SUB: begin dp_alu = ALUCTRL_W'(ALU_SUB); dp_arith = 1'b1; end
      CMD_CMP: begin dp_alu = ALUCTRL_W'(ALU_SUB); dp_arith = 1'b1; end
      CMD_AND: dp_alu = ALUCTRL_W'(ALU_AND);
      CMD_ORR: dp_alu = ALUCTRL_W'(ALU_ORR);
      CMD_EOR: dp_alu = ALUCTRL_W'(ALU_EOR);
      CMD_MOV: dp_alu = ALUCTRL_W'(ALU_MOV);
      default: dp_valid = 1'b0;
    endcase
  end

  // CMP updates flags regardless of S; logical ops only touch NZ
  assign dp_nz_we = is_cmp | (s_bit & dp_valid);
  assign dp_cv_we = is_cmp | (s_bit & dp_arith);
  assign no_write = (op == OP_DP) & ~is_mul & ~dp_valid;

  // Next-state and per-state control outputs
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    next_pc    = 1'b0;
    branch     = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    ir_w       = 1'b0;
    adr_src    = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_ctrl   = ALUCTRL_W'(ALU_ADD);
    nz_we      = 1'b0;
    cv_we      = 1'b0;
    unique case (state_q)
      FETCH: begin
        ir_w       = 1'b1;
        next_pc    = 1'b1;
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        state_d    = DECODE;
      end
      DECODE: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (op == OP_MEM)     state_d = MEMADR;
        else if (op == OP_BR) state_d = BRANCH;
        else if (op == OP_DP) begin
          if (is_mul)        state_d = MULEX;
          else if (funct[5]) state_d = EXECI;
          else               state_d = EXECR;
        end else             state_d = FETCH;
      end
      MEMADR: begin
        alu_src_b = 2'b01;
        state_d   = funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        adr_src = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_w      = 1'b1;
        state_d    = FETCH;
      end
      MEMWR: begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
        state_d = FETCH;
      end
      EXECR, EXECI: begin
        alu_src_b = (state_q == EXECI) ? 2'b01 : 2'b00;
        alu_ctrl  = dp_alu;
        nz_we     = dp_nz_we;
        cv_we     = dp_cv_we;
        state_d   = is_cmp ? FETCH : ALUWB;
      end
      MULEX: begin
        alu_ctrl = ALUCTRL_W'(ALU_MUL);
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          nz_we   = s_bit;
          state_d = ALUWB;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ALUWB: begin
        reg_w   = 1'b1;
        state_d = FETCH;
      end
      BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        branch     = 1'b1;
        state_d    = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // State and MUL cycle counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  arm_mc_condlogic u_cond (
    .clk         (clk),
    .reset       (reset),
    .cond_i      (bus.Instr[31:28]),
    .alu_flags_i (bus.ALUFlags),
    .nz_we_i     (nz_we),
    .cv_we_i     (cv_we),
    .cond_ex_o   (cond_ex)
  );

  // Write enables are held low for the whole reset pulse
  assign bus.PCWrite    = ~reset & (next_pc | ((branch | (reg_w & (rd == 4'hF))) & cond_ex));
  assign bus.RegWrite   = ~reset & reg_w & cond_ex & ~no_write;
  assign bus.MemWrite   = ~reset & mem_w & cond_ex;
  assign bus.IRWrite    = ~reset & ir_w;
  assign bus.AdrSrc     = adr_src;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUControl = alu_ctrl;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ImmSrc     = op;
  assign bus.RegSrc     = {(op == OP_MEM) & ~funct[0], (op == OP_BR)};

endmodule

// File: tb/tb_arm_mc_controller.sv
// Randomized bench for arm_mc_controller with an instruction-level reference model.
module tb_arm_mc_controller;
  localparam int unsigned MulCycles = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  arm_mc_controller_if #(.ALUCTRL_W(4)) bus ();
  arm_mc_controller_if #(.ALUCTRL_W(4)) bus0 ();
  assign bus0.Instr    = bus.Instr;
  assign bus0.ALUFlags = bus.ALUFlags;

  arm_mc_controller #(.ALUCTRL_W(4), .EN_MUL(1'b1), .MUL_CYCLES(MulCycles)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  arm_mc_controller #(.ALUCTRL_W(4), .EN_MUL(1'b0), .MUL_CYCLES(MulCycles)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.master)
  );

  typedef struct {
    bit       nextpc, branch, regw, memw, irw, adr, wnz, wcv, nowr;
    bit [1:0] rsrc, srca, srcb;
    bit [3:0] aluc;
  } cyc_t;

  int checks = 0;
  int errors = 0;

  bit [3:0] m_flags = 4'b0000;
  bit       fix_alu = 1'b0;
  bit [3:0] fix_val = 4'b0000;
  bit [3:0] cmds [7] = '{4'h4, 4'h2, 4'hA, 4'h0, 4'hC, 4'h1, 4'hD};

  bit       exp_valid = 1'b0;
  bit       exp_pcw, exp_adr, exp_memw, exp_irw, exp_regw;
  bit [1:0] exp_rsrc, exp_srca, exp_srcb, exp_immsrc, exp_regsrc;
  bit [3:0] exp_aluc, exp_flags;

  bit       tr_pcw [$];
  bit       tr_regw [$];
  bit       tr_memw [$];
  bit       tr_adr [$];
  bit [3:0] tr_aluc [$];
  bit [1:0] tr_rsrc [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Standard ARM condition table, pairs of conditions share a test and differ by Cond[0]
  function automatic bit cond_ok(input bit [3:0] cond, input bit [3:0] f);
    bit n, z, c, v, r;
    {n, z, c, v} = f;
    case (cond[3:1])
      3'd0: r = z;
      3'd1: r = c;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = c && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: return cond[0] == 1'b0;
    endcase
    return cond[0] ? !r : r;
  endfunction

  function automatic cyc_t blank();
    cyc_t c;
    c = '{default: '0};
    return c;
  endfunction

  function automatic bit cmd_defined(input bit [3:0] cmd);
    foreach (cmds[i]) if (cmds[i] == cmd) return 1'b1;
    return 1'b0;
  endfunction

  // Compare every meaningful cycle
  always @(negedge clk) begin
    if (exp_valid) begin
      chk("PCWrite", bus.PCWrite, exp_pcw);
      chk("AdrSrc", bus.AdrSrc, exp_adr);
      chk("MemWrite", bus.MemWrite, exp_memw);
      chk("IRWrite", bus.IRWrite, exp_irw);
      chk("ResultSrc", bus.ResultSrc, exp_rsrc);
      chk("ALUControl", bus.ALUControl, exp_aluc);
      chk("ALUSrcA", bus.ALUSrcA, exp_srca);
      chk("ALUSrcB", bus.ALUSrcB, exp_srcb);
      chk("ImmSrc", bus.ImmSrc, exp_immsrc);
      chk("RegWrite", bus.RegWrite, exp_regw);
      chk("RegSrc", bus.RegSrc, exp_regsrc);
      chk("flags", dut.u_cond.flags_q, exp_flags);
    end
  end

  // One clock cycle: entered and left at posedge+1
  task automatic step(input cyc_t c, input logic [31:0] ins);
    bit [3:0] af;
    bit cx;
    af = fix_alu ? fix_val : 4'($urandom);
    bus.ALUFlags = af;
    cx = cond_ok(ins[31:28], m_flags);
    exp_pcw    = c.nextpc | ((c.branch | (c.regw & (ins[15:12] == 4'hF))) & cx);
    exp_regw   = c.regw & cx & !c.nowr;
    exp_memw   = c.memw & cx;
    exp_irw    = c.irw;
    exp_adr    = c.adr;
    exp_rsrc   = c.rsrc;
    exp_srca   = c.srca;
    exp_srcb   = c.srcb;
    exp_aluc   = c.aluc;
    exp_immsrc = ins[27:26];
    exp_regsrc = {(ins[27:26] == 2'b01) && !ins[20], ins[27:26] == 2'b10};
    exp_flags  = m_flags;
    exp_valid  = 1'b1;
    if (cx && c.wnz) m_flags[3:2] = af[3:2];
    if (cx && c.wcv) m_flags[1:0] = af[1:0];
    @(negedge clk);
    tr_pcw.push_back(bus.PCWrite);
    tr_regw.push_back(bus.RegWrite);
    tr_memw.push_back(bus.MemWrite);
    tr_adr.push_back(bus.AdrSrc);
    tr_aluc.push_back(bus.ALUControl);
    tr_rsrc.push_back(bus.ResultSrc);
    @(posedge clk);
    #1;
  endtask

  task automatic run_pre(input logic [31:0] ins);
    cyc_t c;
    tr_pcw.delete(); tr_regw.delete(); tr_memw.delete();
    tr_adr.delete(); tr_aluc.delete(); tr_rsrc.delete();
    bus.Instr = ins;
    c = blank(); c.nextpc = 1; c.irw = 1; c.srca = 2'b01; c.srcb = 2'b10; c.rsrc = 2'b10;
    step(c, ins);
    c = blank(); c.srca = 2'b01; c.srcb = 2'b10; c.rsrc = 2'b10;
    step(c, ins);
  endtask

  // Whole instruction from its FETCH cycle up to the next FETCH
  task automatic run_instr(input logic [31:0] ins);
    cyc_t c;
    bit [1:0] op;
    bit [5:0] funct;
    bit [3:0] cmd;
    bit s, mul, arith, def;
    op = ins[27:26]; funct = ins[25:20]; cmd = funct[4:1]; s = funct[0];
    mul = (op == 2'b00) && (funct[5:1] == 5'd0) && (ins[7:4] == 4'b1001);
    run_pre(ins);
    if (op == 2'b01) begin
      c = blank(); c.srcb = 2'b01; step(c, ins);
      if (funct[0]) begin
        c = blank(); c.adr = 1; step(c, ins);
        c = blank(); c.rsrc = 2'b01; c.regw = 1; step(c, ins);
      end else begin
        c = blank(); c.adr = 1; c.memw = 1; step(c, ins);
      end
    end else if (op == 2'b10) begin
      c = blank(); c.srcb = 2'b01; c.rsrc = 2'b10; c.branch = 1; step(c, ins);
    end else if (op == 2'b00) begin
      if (mul) begin
        for (int i = 0; i < MulCycles; i++) begin
          c = blank(); c.aluc = 4'd6; c.wnz = s && (i == MulCycles - 1); step(c, ins);
        end
        c = blank(); c.regw = 1; step(c, ins);
      end else begin
        def = cmd_defined(cmd);
        arith = (cmd == 4'h4) || (cmd == 4'h2) || (cmd == 4'hA);
        c = blank();
        c.srcb = funct[5] ? 2'b01 : 2'b00;
        case (cmd)
          4'h2, 4'hA: c.aluc = 4'd1;
          4'h0: c.aluc = 4'd2;
          4'hC: c.aluc = 4'd3;
          4'h1: c.aluc = 4'd4;
          4'hD: c.aluc = 4'd5;
          default: c.aluc = 4'd0;
        endcase
        c.wnz = (cmd == 4'hA) || (s && def);
        c.wcv = (cmd == 4'hA) || (s && arith);
        step(c, ins);
        if (cmd != 4'hA) begin
          c = blank(); c.regw = 1; c.nowr = !def; step(c, ins);
        end
      end
    end
  endtask

  task automatic do_reset();
    exp_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_PCWrite", bus.PCWrite, 1'b0);
    chk("rst_IRWrite", bus.IRWrite, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_flags = 4'b0000;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    bit [3:0] c;
    int k;
    r = $urandom;
    k = $urandom_range(0, 9);
    r[31:28] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hE;
    case (k)
      0, 1, 2, 9: begin
        r[27:26] = 2'b00;
        r[24:21] = cmds[$urandom_range(0, 6)];
        if (k == 9) r[15:12] = 4'hF;
      end
      3: begin
        r[27:26] = 2'b00;
        do c = 4'($urandom); while (cmd_defined(c));
        r[24:21] = c;
        r[20] = 1'b0;
      end
      4: begin r[27:22] = 6'd0; r[7:4] = 4'b1001; end
      5: begin r[27:26] = 2'b01; r[20] = 1'b1; end
      6: begin r[27:26] = 2'b01; r[20] = 1'b0; end
      7: r[27:26] = 2'b10;
      default: r[27:26] = 2'b11;
    endcase
    return r;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.Instr = 32'h0;
    bus.ALUFlags = 4'h0;
    @(posedge clk);
    #1;
    chk("reset_PCWrite", bus.PCWrite, 1'b0);
    chk("reset_IRWrite", bus.IRWrite, 1'b0);
    chk("reset_RegWrite", bus.RegWrite, 1'b0);
    chk("reset_MemWrite", bus.MemWrite, 1'b0);
    chk("reset_flags", dut.u_cond.flags_q, 4'b0000);
    chk("reset_cnt", dut.cnt_q, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    run_instr(32'hE2801005);
    chk("add_len", tr_pcw.size(), 4);
    chk("add_aluc_execi", tr_aluc[2], 4'd0);
    chk("add_regw_exec", tr_regw[2], 1'b0);
    chk("add_regw_aluwb", tr_regw[3], 1'b1);

    run_instr(32'hE5912004);
    chk("ldr_len", tr_pcw.size(), 5);
    chk("ldr_adr_memrd", tr_adr[3], 1'b1);
    chk("ldr_rsrc_memwb", tr_rsrc[4], 2'b01);
    chk("ldr_regw_memwb", tr_regw[4], 1'b1);

    run_instr(32'hE5812004);
    chk("str_len", tr_pcw.size(), 4);
    chk("str_memw", tr_memw[3], 1'b1);

    fix_alu = 1'b1; fix_val = 4'b0100;
    run_instr(32'hE1500001);
    fix_alu = 1'b0;
    chk("cmp_len", tr_pcw.size(), 3);
    chk("cmp_flags", dut.u_cond.flags_q, 4'b0100);
    chk("cmp_regw", tr_regw[2], 1'b0);

    run_instr(32'h0A000002);
    chk("beq_pcw", tr_pcw[2], 1'b1);
    run_instr(32'h1A000002);
    chk("bne_pcw", tr_pcw[2], 1'b0);

    fix_alu = 1'b1; fix_val = 4'b0011;
    run_instr(32'hE1500001);
    fix_val = 4'b1011;
    run_instr(32'hE2110000);
    fix_alu = 1'b0;
    chk("ands_flags", dut.u_cond.flags_q, 4'b1011);

    run_instr(32'hF2801005);
    chk("nv_regw", tr_regw[3], 1'b0);
    chk("nv_pcw", tr_pcw[3], 1'b0);

    run_instr(32'hE0030291);
    chk("mul_len", tr_pcw.size(), 7);
    for (int i = 2; i < 6; i++) chk("mul_aluc", tr_aluc[i], 4'd6);
    chk("mul_regw", tr_regw[6], 1'b1);

    for (int n = 0; n < 150; n++) run_instr(rand_instr());

    // Realign both instances, then interrupt a MUL mid-flight
    do_reset();
    fix_alu = 1'b1; fix_val = 4'b0100;
    run_instr(32'hE1500001);
    fix_alu = 1'b0;
    run_pre(32'hE0130291);
    #1;
    chk("nomul_aluc", bus0.ALUControl, 4'd2);
    chk("nomul_srcb", bus0.ALUSrcB, 2'b00);
    step('{aluc: 4'd6, default: '0}, 32'hE0130291);
    #1;
    chk("nomul_regw", bus0.RegWrite, 1'b1);
    exp_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("midmul_aluc", bus.ALUControl, 4'd0);
    chk("midmul_flags", dut.u_cond.flags_q, 4'b0000);
    chk("midmul_cnt", dut.cnt_q, 0);
    chk("midmul_IRWrite", bus.IRWrite, 1'b0);
    chk("midmul_PCWrite", bus.PCWrite, 1'b0);
    chk("midmul_RegWrite", bus.RegWrite, 1'b0);
    chk("midmul_MemWrite", bus.MemWrite, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_flags = 4'b0000;
    run_instr(32'hE2801005);
    chk("resume_len", tr_pcw.size(), 4);

    exp_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
